// File: rtl/fifo_uart_pkg.sv
// Shared definitions for the nibble-FIFO to UART 8N1 transmitter.
package fifo_uart_pkg;

    typedef logic [2:0] state_t;

    localparam state_t IDLE  = 3'd0;
    localparam state_t POP   = 3'd1;
    localparam state_t CAP   = 3'd2;
    localparam state_t START = 3'd3;
    localparam state_t DATA  = 3'd4;
    localparam state_t STOP  = 3'd5;

    localparam int FRAME_BITS           = 10;
    localparam int DEFAULT_CLKS_PER_BIT = 16;

    function automatic int frame_cycles(input int clks_per_bit);
        return FRAME_BITS * clks_per_bit;
    endfunction

endpackage

// File: rtl/fifo_uart_tx_bit_timer.sv
// Baud timer: down-counter loaded at each bit boundary, pulses bit_end on the
// final cycle of a bit.
module uart_bit_timer #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    output logic bit_end
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] RELOAD = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt;
    logic          active;

    // load wins over expiry so back-to-back bits keep exact length
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt    <= '0;
            active <= 1'b0;
        end else if (load) begin
            cnt    <= RELOAD;
            active <= 1'b1;
        end else if (active) begin
            if (cnt == '0) begin
                active <= 1'b0;
            end else begin
                cnt <= cnt - CW'(1);
            end
        end
    end

    assign bit_end = active && (cnt == '0);

endmodule

// File: rtl/fifo_uart_tx.sv
// Pops two nibbles from the FIFO read port (low nibble first) and sends the
// resulting byte as a UART 8N1 frame on tx.
//
// state | meaning
// IDLE  | line high; wait for FIFO not empty
// POP   | fifo_rinc pulse
// CAP   | capture fifo_rdata into low/high half of shreg
// START | start bit (tx=0)
// DATA  | 8 data bits, LSB first
// STOP  | stop bit (tx=1), byte_done on last cycle
module fifo_uart_tx
    import fifo_uart_pkg::*;
#(
    parameter int DATA_WIDTH   = 4,
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_rdata,
    output logic                  fifo_rinc,
    output logic                  tx,
    output logic                  busy,
    output logic                  byte_done
);

    state_t     state;
    state_t     state_nx;
    logic       nib_sel;
    logic [7:0] shreg;
    logic [2:0] bit_idx;
    logic       bit_end;
    logic       timer_load;

    uart_bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_bit_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (timer_load),
        .bit_end (bit_end)
    );

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (!fifo_empty) state_nx = POP;
            POP:     state_nx = CAP;
            CAP:     state_nx = nib_sel ? START : IDLE;
            START:   if (bit_end) state_nx = DATA;
            DATA:    if (bit_end && (bit_idx == 3'd7)) state_nx = STOP;
            STOP:    if (bit_end) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Reload at entry to START and at every bit boundary up to the stop bit
    assign timer_load = ((state == CAP) && nib_sel)
                      || (bit_end && ((state == START) || (state == DATA)));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            nib_sel <= 1'b0;
            shreg   <= '0;
            bit_idx <= '0;
        end else begin
            state <= state_nx;
            if (state == CAP) begin
                if (nib_sel) begin
                    shreg[7:4] <= fifo_rdata;
                end else begin
                    shreg[3:0] <= fifo_rdata;
                end
                nib_sel <= ~nib_sel;
            end
            if (state == START) begin
                bit_idx <= 3'd0;
            end else if ((state == DATA) && bit_end) begin
                bit_idx <= bit_idx + 3'd1;
            end
        end
    end

    always_comb begin
        tx = 1'b1;
        case (state)
            START:   tx = 1'b0;
            DATA:    tx = shreg[bit_idx];
            default: tx = 1'b1;
        endcase
    end

    assign fifo_rinc = (state == POP);
    assign busy      = (state != IDLE) || nib_sel;
    assign byte_done = (state == STOP) && bit_end;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Directed bench for fifo_uart_tx: FIFO model, UART frame checker, scoreboard.
module tb_fifo_uart_tx;

    localparam int CPB   = 4;
    localparam int FRAME = 10 * CPB;

    logic       clk        = 1'b0;
    logic       rst_n      = 1'b0;
    logic       fifo_empty = 1'b1;
    logic [3:0] fifo_rdata = 4'h0;
    logic       fifo_rinc;
    logic       tx;
    logic       busy;
    logic       byte_done;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [3:0] fifo_q[$];
    logic [7:0] exp_q[$];

    bit         in_frame  = 1'b0;
    int         fc        = 0;
    logic [7:0] cur_byte  = 8'h00;
    int         frames    = 0;
    int         aborted   = 0;
    int         rinc_cnt  = 0;
    int         done_cyc  = -1000;
    int         last_gap  = -1;
    int         k;
    logic [2:0] bi;
    logic       exp_bit;

    fifo_uart_tx #(
        .DATA_WIDTH   (4),
        .CLKS_PER_BIT (CPB)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .fifo_empty (fifo_empty),
        .fifo_rdata (fifo_rdata),
        .fifo_rinc  (fifo_rinc),
        .tx         (tx),
        .busy       (busy),
        .byte_done  (byte_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // FIFO model: one-cycle read latency, empty flag updated on the clock
    always @(posedge clk) begin
        if (fifo_rinc) begin
            if (fifo_q.size() > 0) fifo_rdata <= fifo_q.pop_front();
            else fifo_rdata <= 4'hx;
        end
        fifo_empty <= (fifo_q.size() == 0);
    end

    // Frame checker: compares every tx cycle of a frame against the scoreboard head
    always @(negedge clk) begin
        if (fifo_rinc) begin
            rinc_cnt++;
            check("rinc_while_empty", 32'(fifo_empty), 32'(1'b0));
        end
        if (!rst_n) begin
            if (in_frame) begin
                if (exp_q.size() > 0) void'(exp_q.pop_front());
                aborted++;
            end
            in_frame = 1'b0;
        end else begin
            if (!in_frame) begin
                if (tx === 1'b0) begin
                    in_frame = 1'b1;
                    fc       = 0;
                    last_gap = cyc - done_cyc;
                    check("frame_expected", 32'(exp_q.size() != 0), 32'(1'b1));
                    cur_byte = (exp_q.size() != 0) ? exp_q[0] : 8'h00;
                end else begin
                    check("byte_done_idle", 32'(byte_done), 32'(1'b0));
                end
            end
            if (in_frame) begin
                k = fc / CPB;
                if (k == 0) begin
                    exp_bit = 1'b0;
                end else if (k <= 8) begin
                    bi      = 3'(k - 1);
                    exp_bit = cur_byte[bi];
                end else begin
                    exp_bit = 1'b1;
                end
                check("tx_bit", 32'(tx), 32'(exp_bit));
                check("byte_done", 32'(byte_done), 32'(fc == FRAME - 1));
                if (fc == FRAME - 1) begin
                    if (exp_q.size() > 0) void'(exp_q.pop_front());
                    frames++;
                    done_cyc = cyc;
                    in_frame = 1'b0;
                end else begin
                    fc++;
                end
            end
        end
    end

    task automatic push_nib(input logic [3:0] n);
        fifo_q.push_back(n);
    endtask

    task automatic wait_frames(input int target, input int budget);
        int n = 0;
        while (frames < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("frame_timeout", 32'(frames >= target), 32'(1'b1));
    endtask

    initial begin
        int c0;
        int n;
        int base_rinc;
        int base_frames;
        int base_abort;

        // Reset
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_tx", 32'(tx), 32'(1'b1));
        check("rst_rinc", 32'(fifo_rinc), 32'(1'b0));
        check("rst_busy", 32'(busy), 32'(1'b0));
        check("rst_byte_done", 32'(byte_done), 32'(1'b0));
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Byte 0xA5 from nibbles 0x5, 0xA
        base_rinc = rinc_cnt;
        push_nib(4'h5);
        push_nib(4'hA);
        exp_q.push_back(8'hA5);
        @(negedge clk);
        check("empty_seen", 32'(fifo_empty), 32'(1'b0));
        c0 = cyc;
        n  = 0;
        while (tx !== 1'b0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("start_latency", cyc - c0, 6);
        wait_frames(1, FRAME + 20);
        check("rinc_pulses", rinc_cnt - base_rinc, 2);
        repeat (2) @(negedge clk);
        check("idle_busy", 32'(busy), 32'(1'b0));
        check("idle_tx", 32'(tx), 32'(1'b1));

        // Empty FIFO: nothing happens
        repeat (30) begin
            @(negedge clk);
            check("empty_rinc", 32'(fifo_rinc), 32'(1'b0));
            check("empty_tx", 32'(tx), 32'(1'b1));
            check("empty_busy", 32'(busy), 32'(1'b0));
        end

        // Half-byte hold: 0x3, long gap, then 0xC
        base_frames = frames;
        push_nib(4'h3);
        repeat (4) @(negedge clk);
        repeat (50) begin
            @(negedge clk);
            check("hold_busy", 32'(busy), 32'(1'b1));
            check("hold_tx", 32'(tx), 32'(1'b1));
        end
        check("hold_no_frame", frames, base_frames);
        push_nib(4'hC);
        exp_q.push_back(8'hC3);
        wait_frames(base_frames + 1, FRAME + 20);

        // Reset during data bit 4 truncates the frame
        base_frames = frames;
        base_abort  = aborted;
        push_nib(4'h7);
        push_nib(4'hE);
        exp_q.push_back(8'hE7);
        n = 0;
        while (!(in_frame && fc >= 5 * CPB + 1 && fc <= 6 * CPB - 1) && n < FRAME + 20) begin
            @(negedge clk);
            n++;
        end
        check("reached_bit4", 32'(in_frame), 32'(1'b1));
        rst_n = 1'b0;
        @(negedge clk);
        check("midrst_tx", 32'(tx), 32'(1'b1));
        check("midrst_busy", 32'(busy), 32'(1'b0));
        check("midrst_rinc", 32'(fifo_rinc), 32'(1'b0));
        check("midrst_byte_done", 32'(byte_done), 32'(1'b0));
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("midrst_aborted", aborted - base_abort, 1);
        check("midrst_no_frame", frames, base_frames);
        check("midrst_sb_empty", exp_q.size(), 0);
        push_nib(4'h1);
        push_nib(4'h2);
        exp_q.push_back(8'h21);
        wait_frames(base_frames + 1, FRAME + 20);

        // Back-to-back: 0x21 then 0x43, second start 7 cycles after byte_done
        base_frames = frames;
        base_rinc   = rinc_cnt;
        push_nib(4'h1);
        push_nib(4'h2);
        push_nib(4'h3);
        push_nib(4'h4);
        exp_q.push_back(8'h21);
        exp_q.push_back(8'h43);
        wait_frames(base_frames + 2, 2 * FRAME + 40);
        check("b2b_gap", last_gap, 7);
        check("b2b_rinc", rinc_cnt - base_rinc, 4);
        repeat (3) @(negedge clk);
        check("final_busy", 32'(busy), 32'(1'b0));
        check("final_sb_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
